// File: rtl/tls_pkg.sv
// Shared phase encodings and helpers for the traffic-light phase monitor.
package tls_pkg;

    // Same codes as the controller's state register
    typedef enum logic [1:0] {
        PH_G    = 2'b00,
        PH_Y    = 2'b01,
        PH_R    = 2'b10,
        PH_IDLE = 2'b11
    } phase_t;

    localparam int unsigned TW_DEF = 4;
    localparam int unsigned RW_DEF = 8;

    // Programmed time 0 means a full wrap of the controller's TW-bit counter
    function automatic int unsigned exp_of(input int unsigned t, input int unsigned tw);
        return (t == 0) ? (32'd1 << tw) : t;
    endfunction

endpackage

// File: rtl/tls_phase_timer.sv
// Counts non-Stop cycles of the current lamp phase and remembers whether
// a Jump was seen while the phase was one that Jump may cut short.
module tls_phase_timer
    import tls_pkg::*;
#(
    parameter int unsigned TW = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic          advance,
    input  logic          stop,
    input  logic          jump,
    input  logic          jump_ok,
    output logic [TW:0]   cnt,
    output logic          jump_seen
);

    // clear on Set, reload on a phase change, otherwise count the held phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            jump_seen <= 1'b0;
        end else if (clear) begin
            cnt       <= '0;
            jump_seen <= 1'b0;
        end else if (load) begin
            cnt       <= stop ? '0 : (TW+1)'(1);
            jump_seen <= jump & jump_ok;
        end else if (advance) begin
            if (!stop && (cnt != '1))
                cnt <= cnt + (TW+1)'(1);
            if (jump && jump_ok)
                jump_seen <= 1'b1;
        end
    end

endmodule

// File: rtl/tls_phase_monitor.sv
// Lamp-side observer for the traffic-light controller: tracks the phase
// sequence, measures each phase and flags sequence/duration/lamp errors.
module tls_phase_monitor
    import tls_pkg::*;
#(
    parameter int unsigned TW = TW_DEF,
    parameter int unsigned RW = RW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Set,
    input  logic          Stop,
    input  logic          Jump,
    input  logic [TW-1:0] Gin,
    input  logic [TW-1:0] Yin,
    input  logic [TW-1:0] Rin,
    input  logic          G_lamp,
    input  logic          Y_lamp,
    input  logic          R_lamp,
    output logic          phase_done,
    output logic [1:0]    last_phase,
    output logic [TW:0]   last_dur,
    output logic          last_jump,
    output logic          seq_err,
    output logic          dur_err,
    output logic          lamp_err,
    output logic [RW-1:0] round_cnt
);

    phase_t          phase;
    phase_t          obs;
    logic [TW-1:0]   g_time, y_time, r_time;
    logic [TW:0]     cnt;
    logic [TW:0]     exp_old;
    logic            jump_seen;
    logic            one_hot;
    logic            active;
    logic            changed;
    logic            advance;
    logic            legal;
    logic            jump_ok;

    // Decode the lamps and classify this cycle
    always_comb begin
        one_hot = (G_lamp & ~Y_lamp & ~R_lamp) |
                  (~G_lamp & Y_lamp & ~R_lamp) |
                  (~G_lamp & ~Y_lamp & R_lamp);
        obs     = G_lamp ? PH_G : (Y_lamp ? PH_Y : PH_R);
        active  = (phase != PH_IDLE) && !Set;
        changed = active && one_hot && (obs != phase);
        advance = active && one_hot && (obs == phase);
        // Jump only matters for the phase being entered or held, and only in G/Y
        jump_ok = changed ? (obs != PH_R) : ((phase == PH_G) || (phase == PH_Y));
    end

    // Expected duration and transition legality for the phase being left
    always_comb begin
        exp_old = '0;
        case (phase)
            PH_G:    exp_old = (TW+1)'(exp_of(32'(g_time), TW));
            PH_Y:    exp_old = (TW+1)'(exp_of(32'(y_time), TW));
            PH_R:    exp_old = (TW+1)'(exp_of(32'(r_time), TW));
            default: exp_old = '0;
        endcase
        legal = 1'b0;
        if (phase == PH_G && obs == PH_Y)
            legal = 1'b1;
        else if (phase == PH_Y && obs == PH_R)
            legal = 1'b1;
        else if (phase == PH_R && obs == PH_G)
            legal = 1'b1;
        else if (phase == PH_G && obs == PH_R)
            legal = jump_seen;
    end

    tls_phase_timer #(.TW(TW)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (Set),
        .load      (changed),
        .advance   (advance),
        .stop      (Stop),
        .jump      (Jump),
        .jump_ok   (jump_ok),
        .cnt       (cnt),
        .jump_seen (jump_seen)
    );

    // Phase FSM, completion report, sticky errors and round counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= PH_IDLE;
            g_time     <= '0;
            y_time     <= '0;
            r_time     <= '0;
            phase_done <= 1'b0;
            last_phase <= '0;
            last_dur   <= '0;
            last_jump  <= 1'b0;
            seq_err    <= 1'b0;
            dur_err    <= 1'b0;
            lamp_err   <= 1'b0;
            round_cnt  <= '0;
        end else begin
            phase_done <= 1'b0;
            if (Set) begin
                g_time    <= Gin;
                y_time    <= Yin;
                r_time    <= Rin;
                phase     <= PH_G;
                seq_err   <= 1'b0;
                dur_err   <= 1'b0;
                lamp_err  <= 1'b0;
                round_cnt <= '0;
            end else if (active) begin
                if (!one_hot) begin
                    lamp_err <= 1'b1;
                end else if (changed) begin
                    phase_done <= 1'b1;
                    last_phase <= phase;
                    last_dur   <= cnt;
                    last_jump  <= jump_seen;
                    if (!legal)
                        seq_err <= 1'b1;
                    if (!jump_seen && (cnt != exp_old))
                        dur_err <= 1'b1;
                    if (phase == PH_R && obs == PH_G)
                        round_cnt <= round_cnt + RW'(1);
                    phase <= obs;
                end
            end
        end
    end

endmodule

// File: tb/tb_tls_phase_monitor.sv
// Scoreboard bench for tls_phase_monitor: each expected phase report is
// queued when its closing lamp change is driven and compared on phase_done.
module tb_tls_phase_monitor;
    import tls_pkg::*;

    localparam int unsigned TW = 4;
    localparam int unsigned RW = 8;

    localparam logic [2:0] LG    = 3'b100;
    localparam logic [2:0] LY    = 3'b010;
    localparam logic [2:0] LR    = 3'b001;
    localparam logic [2:0] LGY   = 3'b110;
    localparam logic [2:0] LNONE = 3'b000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          Set = 1'b0;
    logic          Stop = 1'b0;
    logic          Jump = 1'b0;
    logic [TW-1:0] Gin = '0;
    logic [TW-1:0] Yin = '0;
    logic [TW-1:0] Rin = '0;
    logic          G_lamp = 1'b0;
    logic          Y_lamp = 1'b0;
    logic          R_lamp = 1'b0;
    logic          phase_done;
    logic [1:0]    last_phase;
    logic [TW:0]   last_dur;
    logic          last_jump;
    logic          seq_err;
    logic          dur_err;
    logic          lamp_err;
    logic [RW-1:0] round_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int unsigned ph;
        int unsigned dur;
        int unsigned jmp;
        int unsigned seq;
        int unsigned de;
        int unsigned le;
        int unsigned rnd;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    tls_phase_monitor #(.TW(TW), .RW(RW)) dut (
        .clk        (clk),
        .reset      (reset_n),
        .Set        (Set),
        .Stop       (Stop),
        .Jump       (Jump),
        .Gin        (Gin),
        .Yin        (Yin),
        .Rin        (Rin),
        .G_lamp     (G_lamp),
        .Y_lamp     (Y_lamp),
        .R_lamp     (R_lamp),
        .phase_done (phase_done),
        .last_phase (last_phase),
        .last_dur   (last_dur),
        .last_jump  (last_jump),
        .seq_err    (seq_err),
        .dur_err    (dur_err),
        .lamp_err   (lamp_err),
        .round_cnt  (round_cnt)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given lamps/controls; inputs change 1 time unit after the edge
    task automatic cyc(input logic [2:0] l, input logic st = 1'b0, input logic jp = 1'b0);
        {G_lamp, Y_lamp, R_lamp} = l;
        Stop = st;
        Jump = jp;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] l, input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            cyc(l);
    endtask

    task automatic prog(input logic [TW-1:0] g, input logic [TW-1:0] y, input logic [TW-1:0] r);
        Gin = g;
        Yin = y;
        Rin = r;
        Set = 1'b1;
        cyc(LG);
        Set = 1'b0;
    endtask

    task automatic push(input int unsigned ph, input int unsigned dur, input int unsigned jmp,
                        input int unsigned seq, input int unsigned de, input int unsigned le,
                        input int unsigned rnd);
        exp_t e;
        e.ph  = ph;
        e.dur = dur;
        e.jmp = jmp;
        e.seq = seq;
        e.de  = de;
        e.le  = le;
        e.rnd = rnd;
        sb.push_back(e);
    endtask

    task automatic check_errs(input string tag, input int unsigned s, input int unsigned d,
                              input int unsigned l, input int unsigned r);
        check({tag, "_seq_err"},   32'(seq_err),   s);
        check({tag, "_dur_err"},   32'(dur_err),   d);
        check({tag, "_lamp_err"},  32'(lamp_err),  l);
        check({tag, "_round_cnt"}, 32'(round_cnt), r);
    endtask

    // Compare each completion report against the oldest queued expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (phase_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_phase_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("last_phase", 32'(last_phase), e.ph);
                check("last_dur",   32'(last_dur),   e.dur);
                check("last_jump",  32'(last_jump),  e.jmp);
                check("done_seq_err",  32'(seq_err),   e.seq);
                check("done_dur_err",  32'(dur_err),   e.de);
                check("done_lamp_err", 32'(lamp_err),  e.le);
                check("done_round",    32'(round_cnt), e.rnd);
            end
        end
    end

    initial begin
        // reset state
        #12;
        check("rst_phase_done", 32'(phase_done), 0);
        check("rst_last_phase", 32'(last_phase), 0);
        check("rst_last_dur",   32'(last_dur),   0);
        check("rst_last_jump",  32'(last_jump),  0);
        check_errs("rst", 0, 0, 0, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // IDLE ignores lamps, even illegal ones
        run(LGY, 2);
        run(LR, 2);
        check_errs("idle", 0, 0, 0, 0);

        // 1: legal round G3 Y2 R4
        prog(4'd3, 4'd2, 4'd4);
        run(LG, 3);
        push(PH_G, 3, 0, 0, 0, 0, 0);
        run(LY, 2);
        push(PH_Y, 2, 0, 0, 0, 0, 0);
        run(LR, 4);
        push(PH_R, 4, 0, 0, 0, 0, 1);
        run(LG, 2);
        check_errs("t1", 0, 0, 0, 1);

        // 2: Stop pauses green; Stop on the change cycle skips the first yellow cycle
        prog(4'd3, 4'd2, 4'd4);
        cyc(LG);
        cyc(LG, 1'b1);
        cyc(LG, 1'b1);
        cyc(LG);
        cyc(LG);
        push(PH_G, 3, 0, 0, 0, 0, 0);
        cyc(LY, 1'b1);
        cyc(LY);
        cyc(LY);
        push(PH_Y, 2, 0, 0, 0, 0, 0);
        run(LR, 2);
        check_errs("t2", 0, 0, 0, 0);

        // 3: Jump excuses a short green and G->R
        prog(4'd3, 4'd2, 4'd4);
        cyc(LG);
        cyc(LG, 1'b0, 1'b1);
        push(PH_G, 2, 1, 0, 0, 0, 0);
        run(LR, 4);
        push(PH_R, 4, 0, 0, 0, 0, 1);
        run(LG, 2);
        check_errs("t3a", 0, 0, 0, 1);
        // same stream without Jump
        prog(4'd3, 4'd2, 4'd4);
        run(LG, 2);
        push(PH_G, 2, 0, 1, 1, 0, 0);
        run(LR, 2);
        check_errs("t3b", 1, 1, 0, 0);

        // 4: long green flags duration; Set mid-yellow clears and aborts silently
        prog(4'd3, 4'd2, 4'd4);
        run(LG, 3);
        push(PH_G, 3, 0, 0, 0, 0, 0);
        run(LY, 2);
        push(PH_Y, 2, 0, 0, 0, 0, 0);
        run(LR, 4);
        push(PH_R, 4, 0, 0, 0, 0, 1);
        run(LG, 4);
        push(PH_G, 4, 0, 0, 1, 0, 1);
        run(LY, 2);
        check_errs("t4a", 0, 1, 0, 1);
        prog(4'd3, 4'd2, 4'd4);
        check_errs("t4b", 0, 0, 0, 0);

        // 5: two lamps lit, then no lamp lit: lamp_err, phase and count hold
        cyc(LG);
        cyc(LGY);
        check("t5_lamp_err_gy", 32'(lamp_err), 1);
        run(LG, 2);
        push(PH_G, 3, 0, 0, 0, 1, 0);
        run(LY, 2);
        prog(4'd3, 4'd2, 4'd4);
        check("t5_lamp_err_clr", 32'(lamp_err), 0);
        cyc(LG);
        cyc(LNONE);
        check("t5_lamp_err_none", 32'(lamp_err), 1);
        run(LG, 2);
        push(PH_G, 3, 0, 0, 0, 1, 0);
        run(LY, 2);

        // 6: programmed 0 means 16 cycles; async reset mid-red
        prog(4'd0, 4'd2, 4'd4);
        run(LG, 16);
        push(PH_G, 16, 0, 0, 0, 0, 0);
        run(LY, 2);
        push(PH_Y, 2, 0, 0, 0, 0, 0);
        run(LR, 2);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_phase_done", 32'(phase_done), 0);
        check("areset_last_phase", 32'(last_phase), 0);
        check("areset_last_dur",   32'(last_dur),   0);
        check_errs("areset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run(LY, 1);
        run(LG, 2);
        cyc(LNONE);
        cyc(LR);
        check_errs("post_reset", 0, 0, 0, 0);

        run(LG, 2);
        check("sb_empty", unsigned'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
